// File: rtl/fdma_axi_mem_slave_if.sv
// AXI4 memory-mapped bus bundle between the FDMA master and the on-chip memory slave.
// The master modport drives address, write data and ready for responses; the slave modport drives the rest.
interface fdma_axi_mem_slave_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/fdma_axi_mem_slave.sv
// AXI4 slave backed by a 2^MEM_AW x 32 on-chip memory. Independent write and read
// FSMs, one outstanding burst each, every burst executed as INCR with word-index wrap.
// Unsupported size or burst type is reported as SLVERR; a bad size also blocks
// memory writes and zeroes read data.
module fdma_axi_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_AW             = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  fdma_axi_mem_slave_if.slave s_axi
);

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [2:0]        SIZE_WORD   = 3'b010;
  localparam logic [1:0]        BURST_INCR  = 2'b01;
  localparam logic [MEM_AW-1:0] IDX_ONE     = 1;
  localparam int                NBYTES      = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

  // Address bits outside the word index are intentionally ignored
  logic [C_S_AXI_ADDR_WIDTH-1:0] unused_addr;
  assign unused_addr = s_axi.awaddr ^ s_axi.araddr;

  // ---------------- write side ----------------
  w_state_t                    w_state_reg, w_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_reg, bid_next;
  logic [MEM_AW-1:0]           w_idx_reg, w_idx_next;
  logic [7:0]                  w_len_reg, w_len_next;
  logic [7:0]                  w_cnt_reg, w_cnt_next;
  logic                        w_err_reg, w_err_next;    // any SLVERR cause seen so far
  logic                        w_serr_reg, w_serr_next;  // bad size: suppress memory writes
  logic [1:0]                  bresp_reg, bresp_next;
  logic                        awready_reg, wready_reg, bvalid_reg;
  logic                        mem_we;

  // Write FSM next-state and burst bookkeeping
  always_comb begin
    w_state_next = w_state_reg;
    bid_next     = bid_reg;
    w_idx_next   = w_idx_reg;
    w_len_next   = w_len_reg;
    w_cnt_next   = w_cnt_reg;
    w_err_next   = w_err_reg;
    w_serr_next  = w_serr_reg;
    bresp_next   = bresp_reg;
    mem_we       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (s_axi.awvalid && awready_reg) begin
          bid_next     = s_axi.awid;
          w_idx_next   = s_axi.awaddr[MEM_AW+1:2];
          w_len_next   = s_axi.awlen;
          w_cnt_next   = 8'd0;
          w_serr_next  = (s_axi.awsize != SIZE_WORD);
          w_err_next   = (s_axi.awsize != SIZE_WORD) || (s_axi.awburst != BURST_INCR);
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_reg) begin
          mem_we     = !w_serr_reg;
          w_idx_next = w_idx_reg + IDX_ONE;
          w_cnt_next = w_cnt_reg + 8'd1;
          // Burst length comes from AWLEN; WLAST is only checked against it
          if (w_cnt_reg == w_len_reg) begin
            bresp_next   = (w_err_reg || !s_axi.wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state_next = W_RESP;
          end else if (s_axi.wlast) begin
            w_err_next = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready && bvalid_reg) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write FSM state and registered handshake outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_reg <= W_IDLE;
      bid_reg     <= '0;
      w_idx_reg   <= '0;
      w_len_reg   <= '0;
      w_cnt_reg   <= '0;
      w_err_reg   <= 1'b0;
      w_serr_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      bid_reg     <= bid_next;
      w_idx_reg   <= w_idx_next;
      w_len_reg   <= w_len_next;
      w_cnt_reg   <= w_cnt_next;
      w_err_reg   <= w_err_next;
      w_serr_reg  <= w_serr_next;
      bresp_reg   <= bresp_next;
      awready_reg <= (w_state_next == W_IDLE);
      wready_reg  <= (w_state_next == W_DATA);
      bvalid_reg  <= (w_state_next == W_RESP);
    end
  end

  // Byte-enabled memory write port; contents are deliberately not reset
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_reg][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t                      r_state_reg, r_state_next;
  logic [C_S_AXI_ID_WIDTH-1:0]   rid_reg, rid_next;
  logic [MEM_AW-1:0]             r_idx_reg, r_idx_next;
  logic [7:0]                    r_len_reg, r_len_next;
  logic [7:0]                    r_cnt_reg, r_cnt_next;
  logic                          r_serr_reg, r_serr_next;
  logic [1:0]                    rresp_reg, rresp_next;
  logic                          rlast_reg, rlast_next;
  logic                          arready_reg, rvalid_reg;
  logic                          rd_en;
  logic [MEM_AW-1:0]             rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

  // Read FSM next-state; the next beat is fetched on each accepted non-last beat
  always_comb begin
    r_state_next = r_state_reg;
    rid_next     = rid_reg;
    r_idx_next   = r_idx_reg;
    r_len_next   = r_len_reg;
    r_cnt_next   = r_cnt_reg;
    r_serr_next  = r_serr_reg;
    rresp_next   = rresp_reg;
    rlast_next   = rlast_reg;
    rd_en        = 1'b0;
    rd_idx       = r_idx_reg;
    case (r_state_reg)
      R_IDLE: begin
        if (s_axi.arvalid && arready_reg) begin
          rid_next     = s_axi.arid;
          r_idx_next   = s_axi.araddr[MEM_AW+1:2];
          r_len_next   = s_axi.arlen;
          r_cnt_next   = 8'd0;
          r_serr_next  = (s_axi.arsize != SIZE_WORD);
          rresp_next   = ((s_axi.arsize != SIZE_WORD) || (s_axi.arburst != BURST_INCR))
                         ? RESP_SLVERR : RESP_OKAY;
          rlast_next   = (s_axi.arlen == 8'd0);
          rd_en        = 1'b1;
          rd_idx       = s_axi.araddr[MEM_AW+1:2];
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready && rvalid_reg) begin
          if (rlast_reg) begin
            rlast_next   = 1'b0;
            r_state_next = R_IDLE;
          end else begin
            r_idx_next = r_idx_reg + IDX_ONE;
            r_cnt_next = r_cnt_reg + 8'd1;
            rlast_next = ((r_cnt_reg + 8'd1) == r_len_reg);
            rd_en      = 1'b1;
            rd_idx     = r_idx_reg + IDX_ONE;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM state, registered handshake outputs and registered memory read
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_reg <= R_IDLE;
      rid_reg     <= '0;
      r_idx_reg   <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_serr_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rlast_reg   <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      rid_reg     <= rid_next;
      r_idx_reg   <= r_idx_next;
      r_len_reg   <= r_len_next;
      r_cnt_reg   <= r_cnt_next;
      r_serr_reg  <= r_serr_next;
      rresp_reg   <= rresp_next;
      rlast_reg   <= rlast_next;
      arready_reg <= (r_state_next == R_IDLE);
      rvalid_reg  <= (r_state_next == R_DATA);
      if (rd_en) rdata_reg <= r_serr_next ? '0 : mem[rd_idx];
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bid     = bid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rid     = rid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rlast   = rlast_reg;

endmodule

// File: tb/tb_fdma_axi_mem_slave.sv
// Self-checking bench for fdma_axi_mem_slave: a reference memory model feeds
// expected B responses and R beats into queues that are popped as the DUT answers.
module tb_fdma_axi_mem_slave;
  localparam int LIM = 2000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdma_axi_mem_slave_if #(.ID_W(1), .ADDR_W(32), .DATA_W(32)) bus ();

  fdma_axi_mem_slave #(
    .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .MEM_AW(10)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .s_axi(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl [0:1023];
  logic [31:0] wbuf [0:255];
  logic [2:0]  bq [$];      // {id, resp}
  logic [31:0] rq [$];      // expected read data, one per beat

  // Count one comparison and report it when observed differs from expected
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] strb, input int wlast_beat, input bit gaps);
    int t;
    logic size_err;
    logic [1:0] exp_resp;
    logic [2:0] exp_b;
    int base;
    size_err = (size != 3'b010);
    exp_resp = (size_err || burst != 2'b01 || (wlast_beat >= 0 && wlast_beat != len)) ? 2'b10 : 2'b00;
    bq.push_back({id, exp_resp});
    base = int'(addr[11:2]);
    @(negedge clk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = size;
    bus.awburst = burst; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) check("aw_timeout", 0, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("aw_next_awready", bus.awready, 0);
    check("aw_next_wready", bus.wready, 1);
    for (int i = 0; i <= len; i++) begin
      if (gaps && (i % 7 == 3)) begin
        bus.wvalid = 1'b0;
        @(negedge clk);
        check("w_gap_wready", bus.wready, 1);
      end
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = strb;
      bus.wlast = (wlast_beat < 0) ? (i == len) : (i == wlast_beat);
      t = 0;
      while (!bus.wready && t < LIM) begin @(negedge clk); t++; end
      if (t >= LIM) check("w_timeout", 0, 1);
      if (!size_err)
        for (int b = 0; b < 4; b++)
          if (strb[b]) mdl[(base + i) % 1024][8*b +: 8] = wbuf[i][8*b +: 8];
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("w_done_bvalid", bus.bvalid, 1);
    check("w_done_wready", bus.wready, 0);
    bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) check("b_timeout", 0, 1);
    exp_b = bq.pop_front();
    check("bresp", bus.bresp, exp_b[1:0]);
    check("bid", bus.bid, exp_b[2]);
    $display("WR id=%0d addr=%h len=%0d size=%0d burst=%0d bresp=%0d", id, addr, len, size, burst, bus.bresp);
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_next_bvalid", bus.bvalid, 0);
    check("b_next_awready", bus.awready, 1);
  endtask

  task automatic axi_read(input logic id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input bit toggle);
    int t, cnt, cyc;
    logic size_err;
    logic [1:0] exp_resp;
    logic held;
    logic [31:0] held_data, exp_d;
    int base;
    size_err = (size != 3'b010);
    exp_resp = (size_err || burst != 2'b01) ? 2'b10 : 2'b00;
    base = int'(addr[11:2]);
    for (int i = 0; i <= len; i++) rq.push_back(size_err ? 32'h0 : mdl[(base + i) % 1024]);
    @(negedge clk);
    bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size;
    bus.arburst = burst; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) check("ar_timeout", 0, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("ar_next_rvalid", bus.rvalid, 1);
    check("ar_next_arready", bus.arready, 0);
    cnt = 0; cyc = 0; held = 1'b0; held_data = '0;
    while (cnt <= len && cyc < LIM) begin
      bus.rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (bus.rvalid) begin
        if (held) check("r_stable", bus.rdata, held_data);
        if (bus.rready) begin
          exp_d = rq.pop_front();
          check("rdata", bus.rdata, exp_d);
          check("rlast", bus.rlast, (cnt == len));
          check("rid", bus.rid, id);
          check("rresp", bus.rresp, exp_resp);
          cnt++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = bus.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.rready = 1'b0;
    if (cnt <= len) check("r_timeout", 0, 1);
    check("r_done_arready", bus.arready, 1);
    $display("RD id=%0d addr=%h len=%0d size=%0d burst=%0d beats=%0d", id, addr, len, size, burst, cnt);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010; bus.awburst = 2'b01;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010;
    bus.arburst = 2'b01; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_outs", {bus.bresp, bus.rresp, bus.bid, bus.rid}, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_arready", bus.arready, 1);
    $display("RESET released");

    // Single-beat write and readback
    wbuf[0] = 32'hA5A5_0001;
    axi_write(1'b1, 32'h10, 0, 3'b010, 2'b01, 4'hF, -1, 1'b0);
    axi_read(1'b0, 32'h10, 0, 3'b010, 2'b01, 1'b0);

    // 256-beat write, read back with RREADY toggling
    for (int i = 0; i < 256; i++) wbuf[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    axi_write(1'b0, 32'h0, 255, 3'b010, 2'b01, 4'hF, -1, 1'b1);
    axi_read(1'b1, 32'h0, 255, 3'b010, 2'b01, 1'b1);

    // Byte strobes
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(1'b0, 32'h40, 0, 3'b010, 2'b01, 4'hF, -1, 1'b0);
    wbuf[0] = 32'h1122_3344;
    axi_write(1'b0, 32'h40, 0, 3'b010, 2'b01, 4'h5, -1, 1'b0);
    axi_read(1'b0, 32'h40, 0, 3'b010, 2'b01, 1'b0);

    // Wrap-around from word 1022
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    axi_write(1'b1, 32'hFF8, 3, 3'b010, 2'b01, 4'hF, -1, 1'b0);
    axi_read(1'b1, 32'hFF8, 3, 3'b010, 2'b01, 1'b0);
    axi_read(1'b0, 32'h0, 1, 3'b010, 2'b01, 1'b0);

    // Bad size: SLVERR, memory untouched; bad-size read returns zeros
    wbuf[0] = 32'hDEAD_BEEF;
    axi_write(1'b1, 32'h10, 0, 3'b001, 2'b01, 4'hF, -1, 1'b0);
    axi_read(1'b0, 32'h10, 0, 3'b010, 2'b01, 1'b0);
    axi_read(1'b1, 32'h10, 1, 3'b001, 2'b01, 1'b0);

    // Early WLAST on beat 1 of a 4-beat burst
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A00_0000 + 32'(i);
    axi_write(1'b0, 32'h80, 3, 3'b010, 2'b01, 4'hF, 1, 1'b0);
    axi_read(1'b0, 32'h80, 3, 3'b010, 2'b01, 1'b0);

    // Non-INCR burst type: executed as INCR, SLVERR reported
    wbuf[0] = 32'h7777_0000; wbuf[1] = 32'h7777_0001;
    axi_write(1'b1, 32'h300, 1, 3'b010, 2'b10, 4'hF, -1, 1'b0);
    axi_read(1'b1, 32'h300, 1, 3'b010, 2'b00, 1'b0);

    // Concurrent write and read to different addresses
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hABCD_0000 + 32'(i);
    fork
      axi_write(1'b0, 32'h200, 3, 3'b010, 2'b01, 4'hF, -1, 1'b0);
      axi_read(1'b1, 32'h100, 3, 3'b010, 2'b01, 1'b0);
    join
    axi_read(1'b0, 32'h200, 3, 3'b010, 2'b01, 1'b0);

    // Reset in the middle of a read burst
    @(negedge clk);
    bus.arid = 1'b1; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'b010;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < LIM) begin @(negedge clk); t++; end
    if (t >= LIM) check("rst_ar_timeout", 0, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    @(negedge clk);
    check("mid_rvalid", bus.rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_arready", bus.arready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_arready", bus.arready, 1);
    check("mid_rel_awready", bus.awready, 1);
    $display("RESET mid-read done");
    axi_read(1'b0, 32'h10, 0, 3'b010, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound in case a handshake never completes
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end
endmodule
